// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: 640x480@60 defaults,
// counter width and a helper that sums the four segments of a line or frame.
package video_timing_pkg;

  localparam int CNT_W          = 10;
  localparam int MAX_TOTAL      = 1 << CNT_W;
  localparam int MAX_PIPE_DELAY = 15;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_PIPE_DELAY = 2;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_sig_delay.sv
// Synchronous-reset shift register of configurable depth; depth 0 is a wire.
module sig_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = pixclk ^ reset;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_reg [DEPTH];

      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge pixclk) begin
            if (reset) stage_reg[gi] <= RESET_VAL;
            else       stage_reg[gi] <= din;
          end
        end else begin : g_rest
          always_ff @(posedge pixclk) begin
            if (reset) stage_reg[gi] <= RESET_VAL;
            else       stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: early coordinates/strobes for the pixel source and
// a delayed vde/hSync/vSync set aligned to that source's pipeline latency.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic             pixclk,
  input  logic             reset,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active_req,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic             vde,
  output logic             hSync,
  output logic             vSync
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CW1     = CNT_W + 1;

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds counter range");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
      $error("video_timing_gen: PIPE_DELAY out of range 0..15");
    end
  endgenerate

  // Thresholds are one bit wider so a window ending exactly at 1024 still compares correctly.
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   H_ACT_C    = CW1'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_ACT_C    = CW1'(V_ACTIVE);
  localparam logic [CNT_W:0]   HS_BEG_C   = CW1'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]   HS_END_C   = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   VS_BEG_C   = CW1'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   VS_END_C   = CW1'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
  logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST_C) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST_C) ? '0 : v_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  logic [CNT_W:0] h_wide, v_wide;
  logic           h_act, v_act, hs_win, vs_win;

  assign h_wide = {1'b0, h_cnt_reg};
  assign v_wide = {1'b0, v_cnt_reg};
  assign h_act  = h_wide < H_ACT_C;
  assign v_act  = v_wide < V_ACT_C;
  assign hs_win = (h_wide >= HS_BEG_C) && (h_wide < HS_END_C);
  assign vs_win = (v_wide >= VS_BEG_C) && (v_wide < VS_END_C);

  logic [CNT_W-1:0] x_reg, y_reg;
  logic             active_req_reg, line_start_reg, frame_start_reg;
  logic             hsync_early_reg, vsync_early_reg;
  logic [7:0]       frame_cnt_reg;

  always_ff @(posedge pixclk) begin
    if (reset) begin
      x_reg           <= '0;
      y_reg           <= '0;
      active_req_reg  <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hsync_early_reg <= ~HSYNC_POL;
      vsync_early_reg <= ~VSYNC_POL;
      frame_cnt_reg   <= '0;
    end else begin
      x_reg           <= h_cnt_reg;
      y_reg           <= v_cnt_reg;
      active_req_reg  <= h_act && v_act;
      line_start_reg  <= (h_cnt_reg == '0);
      frame_start_reg <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
      hsync_early_reg <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync_early_reg <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      if (frame_start_reg) frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  logic [2:0] out_bus;

  sig_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ({1'b0, ~HSYNC_POL, ~VSYNC_POL})
  ) u_out_delay (
    .pixclk (pixclk),
    .reset  (reset),
    .din    ({active_req_reg, hsync_early_reg, vsync_early_reg}),
    .dout   (out_bus)
  );

  assign x           = x_reg;
  assign y           = y_reg;
  assign active_req  = active_req_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign {vde, hSync, vSync} = out_bus;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-raster instance (PIPE_DELAY 1), the same raster
// with PIPE_DELAY 0, and a 640x480 default instance for start-up, line timing and mid-frame reset.
module tb_video_timing_gen;

  localparam int S_HT = 7;
  localparam int S_VT = 6;
  localparam int S_FT = S_HT * S_VT;

  logic pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  logic rst_s, rst_d;

  logic [9:0] x_s, y_s, x_z, y_z, x_d, y_d;
  logic [7:0] fc_s, fc_z, fc_d;
  logic act_s, ls_s, fs_s, vde_s, hs_s, vs_s;
  logic act_z, ls_z, fs_z, vde_z, hs_z, vs_z;
  logic act_d, ls_d, fs_d, vde_d, hs_d, vs_d;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(1)
  ) dut_s (
    .pixclk(pixclk), .reset(rst_s), .x(x_s), .y(y_s), .active_req(act_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s),
    .vde(vde_s), .hSync(hs_s), .vSync(vs_s)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(0)
  ) dut_z (
    .pixclk(pixclk), .reset(rst_s), .x(x_z), .y(y_z), .active_req(act_z),
    .line_start(ls_z), .frame_start(fs_z), .frame_cnt(fc_z),
    .vde(vde_z), .hSync(hs_z), .vSync(vs_z)
  );

  video_timing_gen dut_d (
    .pixclk(pixclk), .reset(rst_d), .x(x_d), .y(y_d), .active_req(act_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d),
    .vde(vde_d), .hSync(hs_d), .vSync(vs_d)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // Hand-computed vectors for the small raster, indexed by edges since reset release.
  typedef struct {
    int cyc;
    int x; int y;
    bit act; bit ls; bit fs;
    bit vde; bit hs; bit vs;
    int fc;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  // Running state for the per-cycle model and measurements
  bit mon_s = 0, mon_d = 0;
  int n_s = 0, n_d = 0;
  int early_bad = 0, dly_bad = 0, fc_bad = 0, pd0_bad = 0;
  int last_fs_s = 0, fs_seen_s = 0, fsper_bad = 0;
  int vlow_run = 0, vruns = 0, vrun_bad = 0, vde_cnt_s = 0;
  int act_cnt_d = 0, hs_low_d = 0, first_hs_d = 0;
  int last_ls_d = 0, ls_seen_d = 0, ls_bad = 0;

  task automatic model_s();
    int t, h, v, dd, dh, dv, want_fc;
    bit e_act, e_ls, e_fs, e_hs, e_vs, d_vde, d_hs, d_vs;
    t = n_s - 1; h = t % S_HT; v = (t / S_HT) % S_VT;
    e_act = (h < 4) && (v < 3);
    e_ls  = (h == 0);
    e_fs  = (h == 0) && (v == 0);
    e_hs  = !(h == 5);
    e_vs  = !(v == 4);
    if (n_s >= 2) begin
      dd = n_s - 2; dh = dd % S_HT; dv = (dd / S_HT) % S_VT;
      d_vde = (dh < 4) && (dv < 3); d_hs = !(dh == 5); d_vs = !(dv == 4);
      want_fc = ((n_s - 2) / S_FT + 1) % 256;
    end else begin
      d_vde = 1'b0; d_hs = 1'b1; d_vs = 1'b1; want_fc = 0;
    end
    if (x_s !== 10'(h) || y_s !== 10'(v) || act_s !== e_act || ls_s !== e_ls || fs_s !== e_fs)
      early_bad++;
    if (vde_s !== d_vde || hs_s !== d_hs || vs_s !== d_vs) dly_bad++;
    if (fc_s !== 8'(want_fc)) fc_bad++;
    if (x_z !== 10'(h) || act_z !== e_act || vde_z !== e_act || hs_z !== e_hs || vs_z !== e_vs)
      pd0_bad++;
    if (fs_s === 1'b1) begin
      if (last_fs_s > 0 && n_s - last_fs_s != S_FT) fsper_bad++;
      last_fs_s = n_s; fs_seen_s++;
    end
    if (vs_s === 1'b0) vlow_run++;
    else if (vlow_run > 0) begin
      if (vlow_run != S_HT) vrun_bad++;
      vruns++; vlow_run = 0;
    end
    if (n_s >= 2 && n_s <= S_FT * 255 + 1 && vde_s === 1'b1) vde_cnt_s++;
  endtask

  task automatic measure_d();
    if (n_d <= 800) begin
      if (act_d === 1'b1) act_cnt_d++;
      if (hs_d === 1'b0) begin
        hs_low_d++;
        if (first_hs_d == 0) first_hs_d = n_d;
      end
    end
    if (ls_d === 1'b1) begin
      if (last_ls_d > 0 && n_d - last_ls_d != 800) ls_bad++;
      last_ls_d = n_d; ls_seen_d++;
    end
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
    if (mon_s) begin n_s++; model_s(); end
    if (mon_d) begin n_d++; measure_d(); end
  endtask

  // Releases the default instance from reset and checks the first three edges.
  task automatic startup_d(input string tag);
    rst_d = 1'b0; n_d = 0; mon_d = 1;
    act_cnt_d = 0; hs_low_d = 0; first_hs_d = 0; last_ls_d = 0; ls_seen_d = 0; ls_bad = 0;
    tick();
    chk({tag, "_n1_x"}, x_d, 0);
    chk({tag, "_n1_y"}, y_d, 0);
    chk({tag, "_n1_active_req"}, act_d, 1);
    chk({tag, "_n1_line_start"}, ls_d, 1);
    chk({tag, "_n1_frame_start"}, fs_d, 1);
    chk({tag, "_n1_vde_hs_vs"}, {vde_d, hs_d, vs_d}, 3'b011);
    tick();
    chk({tag, "_n2_vde_hs_vs"}, {vde_d, hs_d, vs_d}, 3'b011);
    chk({tag, "_n2_frame_start"}, fs_d, 0);
    chk({tag, "_n2_frame_cnt"}, fc_d, 1);
    tick();
    chk({tag, "_n3_vde"}, vde_d, 1);
  endtask

  initial begin
    vt[0]  = '{1,  0, 0, 1, 1, 1, 0, 1, 1, 0};
    vt[1]  = '{2,  1, 0, 1, 0, 0, 1, 1, 1, 1};
    vt[2]  = '{5,  4, 0, 0, 0, 0, 1, 1, 1, 1};
    vt[3]  = '{6,  5, 0, 0, 0, 0, 0, 1, 1, 1};
    vt[4]  = '{7,  6, 0, 0, 0, 0, 0, 0, 1, 1};
    vt[5]  = '{8,  0, 1, 1, 1, 0, 0, 1, 1, 1};
    vt[6]  = '{9,  1, 1, 1, 0, 0, 1, 1, 1, 1};
    vt[7]  = '{29, 0, 4, 0, 1, 0, 0, 1, 1, 1};
    vt[8]  = '{30, 1, 4, 0, 0, 0, 0, 1, 0, 1};
    vt[9]  = '{36, 0, 5, 0, 1, 0, 0, 1, 0, 1};
    vt[10] = '{37, 1, 5, 0, 0, 0, 0, 1, 1, 1};
    vt[11] = '{42, 6, 5, 0, 0, 0, 0, 0, 1, 1};
    vt[12] = '{43, 0, 0, 1, 1, 1, 0, 1, 1, 1};
    vt[13] = '{44, 1, 0, 1, 0, 0, 1, 1, 1, 2};

    rst_s = 1'b1; rst_d = 1'b1;
    repeat (5) tick();
    chk("rst_s_xy", {x_s, y_s}, 0);
    chk("rst_s_strobes", {act_s, ls_s, fs_s}, 0);
    chk("rst_s_frame_cnt", fc_s, 0);
    chk("rst_s_vde_hs_vs", {vde_s, hs_s, vs_s}, 3'b011);
    chk("rst_z_vde_hs_vs", {vde_z, hs_z, vs_z}, 3'b011);
    chk("rst_d_vde_hs_vs", {vde_d, hs_d, vs_d}, 3'b011);

    // Small raster: table vectors, then run past 257 frames for the frame_cnt wrap
    rst_s = 1'b0; n_s = 0; mon_s = 1;
    for (int i = 0; i < NV; i++) begin
      while (n_s < vt[i].cyc) tick();
      $display("vec cyc=%0d x=%0d y=%0d act=%0b ls=%0b fs=%0b vde=%0b hs=%0b vs=%0b fc=%0d",
               n_s, x_s, y_s, act_s, ls_s, fs_s, vde_s, hs_s, vs_s, fc_s);
      chk($sformatf("vec%0d_x", i), x_s, vt[i].x);
      chk($sformatf("vec%0d_y", i), y_s, vt[i].y);
      chk($sformatf("vec%0d_act_ls_fs", i), {act_s, ls_s, fs_s}, {vt[i].act, vt[i].ls, vt[i].fs});
      chk($sformatf("vec%0d_vde_hs_vs", i), {vde_s, hs_s, vs_s}, {vt[i].vde, vt[i].hs, vt[i].vs});
      chk($sformatf("vec%0d_frame_cnt", i), fc_s, vt[i].fc);
    end
    while (n_s < 10669) tick();
    chk("s_frame_cnt_254", fc_s, 254);
    tick();
    chk("s_frame_cnt_255", fc_s, 255);
    while (n_s < 10712) tick();
    chk("s_frame_cnt_wrap0", fc_s, 0);
    while (n_s < 10754) tick();
    chk("s_frame_cnt_then1", fc_s, 1);
    while (n_s < 10760) tick();
    mon_s = 0;
    chk("s_early_seq_errors", early_bad, 0);
    chk("s_delayed_seq_errors", dly_bad, 0);
    chk("s_frame_cnt_seq_errors", fc_bad, 0);
    chk("s_frame_start_period_errors", fsper_bad, 0);
    chk("s_frame_start_count", fs_seen_s, 257);
    chk("s_vsync_run_len_errors", vrun_bad, 0);
    chk("s_vsync_runs", vruns, 256);
    chk("s_vde_cycles_255_frames", vde_cnt_s, 12 * 255);
    chk("z_pipe0_errors", pd0_bad, 0);

    // Default 640x480 instance: start-up, one line of timing, mid-frame reset
    chk("rst_d_frame_cnt", fc_d, 0);
    startup_d("d_start");
    while (n_d < 1901) tick();
    chk("d_active_cycles_line0", act_cnt_d, 640);
    chk("d_hsync_low_cycles", hs_low_d, 96);
    chk("d_hsync_first_low", first_hs_d, 659);
    chk("d_line_start_period_errors", ls_bad, 0);
    chk("d_line_start_count", ls_seen_d, 3);
    chk("d_pre_reset_x", x_d, 300);
    chk("d_pre_reset_y", y_d, 2);
    chk("d_pre_reset_vde", vde_d, 1);
    chk("d_pre_reset_frame_cnt", fc_d, 1);
    rst_d = 1'b1; mon_d = 0;
    tick();
    chk("d_midrst_vde_hs_vs", {vde_d, hs_d, vs_d}, 3'b011);
    chk("d_midrst_frame_cnt", fc_d, 0);
    chk("d_midrst_xy", {x_d, y_d}, 0);
    chk("d_midrst_strobes", {act_d, ls_d, fs_d}, 0);
    startup_d("d_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
